gestor_burbujas: RTL

- Pipeline stall/bubble controller: the consumer side of the load-use hazard request and the branch-flush request.
- Turns one-cycle requests into multi-cycle PC/fetch-register holds, Exe-stage bubble insertion and fetch flushes.
- Freezes the whole front end while the memory stage is busy.
- Sits between the hazard-detection logic and the PC, F/D-register and Exe-input mux enables; also keeps saturating stall/flush counters for profiling.

---
 rtl/gestor_burbujas.sv | 126 ++++++++++++
 1 files changed

// File: rtl/gestor_burbujas.sv
// Stall/bubble controller: turns load-use hazard and taken-branch requests into
// PC/fetch holds, Exe bubbles and fetch flushes, plus saturating profiling counters.
module gestor_burbujas #(
  parameter int LAT_CARGA    = 1,
  parameter int FLUSH_CICLOS = 2,
  parameter int ANCHO_CNT    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 riesgo_carga,
  input  logic                 salto_tomado,
  input  logic                 mem_ocupado,
  input  logic                 cnt_clr,
  output logic                 PC_EN,
  output logic                 F_Reg_EN,
  output logic                 E_Reg_EN,
  output logic                 NOP_Mux,
  output logic                 flush_F,
  output logic [1:0]           estado,
  output logic [ANCHO_CNT-1:0] cnt_burbujas,
  output logic [ANCHO_CNT-1:0] cnt_vaciados
);

  typedef enum logic [1:0] {
    CORRE   = 2'd0,
    BURBUJA = 2'd1,
    VACIA   = 2'd2
  } estado_e;

  localparam logic [3:0] CARGA_INI = 4'(LAT_CARGA - 1);
  localparam logic [3:0] FLUSH_INI = 4'(FLUSH_CICLOS - 1);

  estado_e              estado_q, estado_d;
  logic [3:0]           cuenta_q, cuenta_d;
  logic [ANCHO_CNT-1:0] cnt_burbujas_q, cnt_vaciados_q;
  logic                 inc_burbujas, inc_vaciados;

  // Outputs stay at their reset values while rst_n is low, whatever the inputs.
  always_comb begin
    PC_EN        = 1'b1;
    F_Reg_EN     = 1'b1;
    E_Reg_EN     = 1'b1;
    NOP_Mux      = 1'b0;
    flush_F      = 1'b0;
    estado_d     = estado_q;
    cuenta_d     = cuenta_q;
    inc_burbujas = 1'b0;
    inc_vaciados = 1'b0;
    if (rst_n) begin
      if (mem_ocupado) begin
        PC_EN    = 1'b0;
        F_Reg_EN = 1'b0;
        E_Reg_EN = 1'b0;
      end else if (salto_tomado) begin
        flush_F      = 1'b1;
        NOP_Mux      = 1'b1;
        inc_vaciados = 1'b1;
        if (FLUSH_CICLOS > 1) begin
          estado_d = VACIA;
          cuenta_d = FLUSH_INI;
        end else begin
          estado_d = CORRE;
          cuenta_d = '0;
        end
      end else begin
        case (estado_q)
          BURBUJA: begin
            PC_EN        = 1'b0;
            F_Reg_EN     = 1'b0;
            NOP_Mux      = 1'b1;
            inc_burbujas = 1'b1;
            cuenta_d     = cuenta_q - 4'd1;
            if (cuenta_q <= 4'd1) estado_d = CORRE;
          end
          VACIA: begin
            flush_F  = 1'b1;
            NOP_Mux  = 1'b1;
            cuenta_d = cuenta_q - 4'd1;
            if (cuenta_q <= 4'd1) estado_d = CORRE;
          end
          default: begin
            // The illegal encoding falls in here and is steered back to CORRE.
            estado_d = CORRE;
            if (riesgo_carga) begin
              PC_EN        = 1'b0;
              F_Reg_EN     = 1'b0;
              NOP_Mux      = 1'b1;
              inc_burbujas = 1'b1;
              if (LAT_CARGA > 1) begin
                estado_d = BURBUJA;
                cuenta_d = CARGA_INI;
              end
            end
          end
        endcase
      end
    end
  end

  // Clear beats increment and is honoured during a freeze; counters never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q       <= CORRE;
      cuenta_q       <= '0;
      cnt_burbujas_q <= '0;
      cnt_vaciados_q <= '0;
    end else begin
      estado_q <= estado_d;
      cuenta_q <= cuenta_d;
      if (cnt_clr) begin
        cnt_burbujas_q <= '0;
        cnt_vaciados_q <= '0;
      end else begin
        if (inc_burbujas && (cnt_burbujas_q != '1))
          cnt_burbujas_q <= cnt_burbujas_q + 1'b1;
        if (inc_vaciados && (cnt_vaciados_q != '1))
          cnt_vaciados_q <= cnt_vaciados_q + 1'b1;
      end
    end
  end

  assign estado       = estado_q;
  assign cnt_burbujas = cnt_burbujas_q;
  assign cnt_vaciados = cnt_vaciados_q;

endmodule
